pwm_duty_serializer: RTL and testbench

//  Upstream feeder for the serial-load PWM stage. Accepts a parallel 8-bit duty value over a

---
 rtl/pwm_duty_serializer_if.sv | 22 ++
 rtl/pwm_duty_serializer.sv | 119 +++++++++++
 tb/tb_pwm_duty_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_serializer_if.sv
// Duty-value handshake plus the serial/PWM-counter bus toward the downstream PWM stage.
interface pwm_duty_serializer_if;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       busy;
    logic       ser_out;
    logic       shift_enable;
    logic       load;
    logic [7:0] counter;
    logic       period_start;

    modport master (
        output duty_in, duty_valid,
        input  duty_ready, busy, ser_out, shift_enable, load, counter, period_start
    );

    modport slave (
        input  duty_in, duty_valid,
        output duty_ready, busy, ser_out, shift_enable, load, counter, period_start
    );
endinterface

// File: rtl/pwm_duty_serializer.sv
// Serialises an accepted 8-bit duty value MSB-first, then pulses load (optionally aligned to
// the PWM counter wrap), and owns the shared prescaled free-running PWM counter.
module pwm_duty_serializer #(
    parameter int PRESCALE  = 1,
    parameter int SYNC_LOAD = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pwm_duty_serializer_if.slave   bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_WRAP, LOAD} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    hold_reg, hold_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [PW-1:0] pcnt_reg, pcnt_next;
    logic [7:0]    counter_reg, counter_next;
    logic          ser_reg, ser_next;
    logic          shift_en_reg, shift_en_next;
    logic          load_reg, load_next;
    logic          busy_reg, busy_next;
    logic          period_start_reg;
    logic          tick;
    logic          wrap_next;

    // Prescaler tick and next counter values; wrap_next looks one cycle ahead so the
    // registered load lands exactly in the counter==255 && tick cycle.
    always_comb begin
        tick         = (pcnt_reg == PCNT_MAX);
        pcnt_next    = tick ? '0 : pcnt_reg + PW'(1);
        counter_next = tick ? counter_reg + 8'd1 : counter_reg;
        wrap_next    = (counter_next == 8'hFF) && (pcnt_next == PCNT_MAX);
    end

    // Free-running prescaler, PWM counter and period-start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_reg         <= '0;
            counter_reg      <= '0;
            period_start_reg <= 1'b0;
        end else begin
            pcnt_reg         <= pcnt_next;
            counter_reg      <= counter_next;
            period_start_reg <= tick && (counter_reg == 8'hFF);
        end
    end

    // Handshake/serialiser next-state logic; outputs are registered one cycle behind the state.
    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        bit_idx_next  = bit_idx_reg;
        ser_next      = 1'b0;
        shift_en_next = 1'b0;
        load_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.duty_valid) begin
                    hold_next    = bus.duty_in;
                    bit_idx_next = 3'd7;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                shift_en_next = 1'b1;
                ser_next      = hold_reg[bit_idx_reg];
                if (bit_idx_reg == 3'd0) begin
                    state_next = (SYNC_LOAD != 0) ? WAIT_WRAP : LOAD;
                end else begin
                    bit_idx_next = bit_idx_reg - 3'd1;
                end
            end
            WAIT_WRAP: begin
                if (wrap_next) begin
                    load_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            LOAD: begin
                load_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // FSM state, held duty value and registered serial-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            hold_reg     <= '0;
            bit_idx_reg  <= '0;
            ser_reg      <= 1'b0;
            shift_en_reg <= 1'b0;
            load_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            bit_idx_reg  <= bit_idx_next;
            ser_reg      <= ser_next;
            shift_en_reg <= shift_en_next;
            load_reg     <= load_next;
            busy_reg     <= busy_next;
        end
    end

    assign bus.duty_ready   = (state_reg == IDLE);
    assign bus.busy         = busy_reg;
    assign bus.ser_out      = ser_reg;
    assign bus.shift_enable = shift_en_reg;
    assign bus.load         = load_reg;
    assign bus.counter      = counter_reg;
    assign bus.period_start = period_start_reg;
endmodule

// File: tb/tb_pwm_duty_serializer.sv
// Bench: two serializer instances (immediate load with PRESCALE=1, wrap-aligned load with
// PRESCALE=4) driven with random duty values, checked every cycle against a cycle-count model.
module tb_pwm_duty_serializer;
    localparam int PRE_A  = 1;
    localparam int SYNC_A = 0;
    localparam int PRE_B  = 4;
    localparam int SYNC_B = 1;

    logic clk;
    logic reset;

    pwm_duty_serializer_if bus_a ();
    pwm_duty_serializer_if bus_b ();

    pwm_duty_serializer #(.PRESCALE(PRE_A), .SYNC_LOAD(SYNC_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    pwm_duty_serializer #(.PRESCALE(PRE_B), .SYNC_LOAD(SYNC_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver state
    logic       drv_valid [2];
    logic [7:0] drv_data  [2];
    assign bus_a.duty_valid = drv_valid[0];
    assign bus_a.duty_in    = drv_data[0];
    assign bus_b.duty_valid = drv_valid[1];
    assign bus_b.duty_in    = drv_data[1];

    // Behavioural downstream PWM stage: shift on shift_enable, latch on load.
    logic [7:0] ds_sr   [2];
    logic [7:0] ds_duty [2];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_sr[0] <= '0; ds_duty[0] <= '0;
        end else begin
            if (bus_a.shift_enable) ds_sr[0] <= {ds_sr[0][6:0], bus_a.ser_out};
            if (bus_a.load) ds_duty[0] <= ds_sr[0];
        end
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_sr[1] <= '0; ds_duty[1] <= '0;
        end else begin
            if (bus_b.shift_enable) ds_sr[1] <= {ds_sr[1][6:0], bus_b.ser_out};
            if (bus_b.load) ds_duty[1] <= ds_sr[1];
        end
    end

    // Reference model state: k = clock edges since reset release.
    int         kc      [2];
    bit         act     [2];
    int         n_acc   [2];
    int         l_edge  [2];
    logic [7:0] t_data  [2];
    logic [7:0] ds_exp  [2];
    bit         pend    [2];
    int         se_run  [2];
    logic [7:0] dq_a [$];
    logic [7:0] dq_b [$];

    int n_cmp;
    int n_bad;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int idx, input logic [7:0] o_cnt, input logic o_ps,
                        input logic o_se, input logic o_ser, input logic o_ld,
                        input logic o_bsy, input logic o_rdy, input logic [7:0] o_ds);
        int    pre, syn, m, k, base;
        bit    e_se, e_ser, e_ld, e_bsy;
        string p;
        pre = (idx == 0) ? PRE_A : PRE_B;
        syn = (idx == 0) ? SYNC_A : SYNC_B;
        m   = 256 * pre;
        p   = (idx == 0) ? "a" : "b";
        if (reset) begin
            kc[idx] = -1; act[idx] = 1'b0; ds_exp[idx] = '0;
            pend[idx] = 1'b0; drv_valid[idx] = 1'b0; se_run[idx] = 0;
            check_val({p, ".rst_counter"}, int'(o_cnt), 0);
            check_val({p, ".rst_period_start"}, int'(o_ps), 0);
            check_val({p, ".rst_shift_enable"}, int'(o_se), 0);
            check_val({p, ".rst_ser_out"}, int'(o_ser), 0);
            check_val({p, ".rst_load"}, int'(o_ld), 0);
            check_val({p, ".rst_busy"}, int'(o_bsy), 0);
            check_val({p, ".rst_duty_ready"}, int'(o_rdy), 1);
            check_val({p, ".rst_ds_duty"}, int'(o_ds), 0);
        end else begin
            kc[idx]++;
            k = kc[idx];
            // Downstream latches on the edge after the load cycle.
            if (act[idx] && k == l_edge[idx] + 1) ds_exp[idx] = t_data[idx];
            // Acceptance at edge k: valid during cycle k-1 while idle.
            if (k >= 1 && drv_valid[idx] && (!act[idx] || (k - 1) >= l_edge[idx])) begin
                act[idx]    = 1'b1;
                n_acc[idx]  = k;
                t_data[idx] = drv_data[idx];
                base        = k + 9;
                if (syn != 0) l_edge[idx] = base + ((m - 1) - (base % m));
                else          l_edge[idx] = base;
                pend[idx]   = 1'b0;
                $display("[%s] accept 0x%02h at k=%0d, load expected at k=%0d",
                         p, t_data[idx], k, l_edge[idx]);
            end
            e_se  = act[idx] && k >= n_acc[idx] + 1 && k <= n_acc[idx] + 8;
            e_ser = e_se ? t_data[idx][7 - (k - n_acc[idx] - 1)] : 1'b0;
            e_ld  = act[idx] && k == l_edge[idx];
            e_bsy = act[idx] && k >= n_acc[idx] && k < l_edge[idx];
            check_val({p, ".counter"}, int'(o_cnt), (k / pre) % 256);
            check_val({p, ".period_start"}, int'(o_ps), (k > 0 && k % m == 0) ? 1 : 0);
            check_val({p, ".shift_enable"}, int'(o_se), int'(e_se));
            check_val({p, ".ser_out"}, int'(o_ser), int'(e_ser));
            check_val({p, ".load"}, int'(o_ld), int'(e_ld));
            check_val({p, ".busy"}, int'(o_bsy), int'(e_bsy));
            check_val({p, ".duty_ready"}, int'(o_rdy), int'(!e_bsy));
            check_val({p, ".ds_duty"}, int'(o_ds), int'(ds_exp[idx]));
            se_run[idx] = o_se ? se_run[idx] + 1 : 0;
            // Drive the next cycle: new value only when nothing is pending.
            if (!pend[idx]) begin
                if (idx == 0 && dq_a.size() > 0) begin
                    drv_data[idx] = dq_a.pop_front(); pend[idx] = 1'b1;
                end else if (idx == 1 && dq_b.size() > 0) begin
                    drv_data[idx] = dq_b.pop_front(); pend[idx] = 1'b1;
                end else if ($urandom_range(0, 3) != 0) begin
                    drv_data[idx] = 8'($urandom); pend[idx] = 1'b1;
                end else begin
                    drv_data[idx] = 8'($urandom);
                end
            end
            drv_valid[idx] = pend[idx];
        end
    endtask

    // Sample away from the active edge and step both models.
    always @(negedge clk) begin
        step(0, bus_a.counter, bus_a.period_start, bus_a.shift_enable, bus_a.ser_out,
             bus_a.load, bus_a.busy, bus_a.duty_ready, ds_duty[0]);
        step(1, bus_b.counter, bus_b.period_start, bus_b.shift_enable, bus_b.ser_out,
             bus_b.load, bus_b.busy, bus_b.duty_ready, ds_duty[1]);
    end

    int guard;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 2; i++) begin
            drv_valid[i] = 1'b0; drv_data[i] = '0; kc[i] = -1; act[i] = 1'b0;
            n_acc[i] = 0; l_edge[i] = 0; t_data[i] = '0; ds_exp[i] = '0;
            pend[i] = 1'b0; se_run[i] = 0;
        end
        dq_a.push_back(8'hA5); dq_a.push_back(8'h00); dq_a.push_back(8'hFF);
        dq_b.push_back(8'hA5); dq_b.push_back(8'h00); dq_b.push_back(8'hFF);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Random traffic long enough for two wraps of the prescaled counter.
        repeat (3000) @(posedge clk);

        // Reset in the middle of a run, then resume.
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (200) @(posedge clk);

        // Reset during the 4th shift cycle of instance a's burst.
        guard = 0;
        while (se_run[0] != 3 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        check_val("a.shift_burst_seen", se_run[0], 3);
        #2 reset = 1'b1;
        dq_a.push_front(8'h3C);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        repeat (2500) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
